// File: rtl/s_term_frame_writer_pkg.sv
// Shared types and constants for the frame writer.
// FRAME_WRITER_CHECKSUM_EN (optional) adds a header^data checksum word to each transaction.
package s_term_frame_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WAIT_CHK,
        SETUP,
        STROBE,
        HOLD
    } frame_writer_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hFA;

    // Header word layout
    localparam int unsigned HDR_SYNC_MSB = 31;
    localparam int unsigned HDR_SYNC_LSB = 24;
    localparam int unsigned HDR_ADDR_MSB = 23;
    localparam int unsigned HDR_ADDR_LSB = 16;

endpackage

// File: rtl/s_term_frame_writer_if.sv
// Upstream valid/ready word stream feeding the frame writer.
interface s_term_frame_writer_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DataWidth-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/s_term_frame_writer_frame_strobe_decoder.sv
// Combinational address-to-one-hot strobe decoder with enable.
module frame_strobe_decoder #(
    parameter int unsigned NumFrames = 20
) (
    input  logic                 en,
    input  logic [7:0]           addr,
    output logic [NumFrames-1:0] strobe
);
    always_comb begin
        strobe = '0;
        for (int unsigned i = 0; i < NumFrames; i++) begin
            if (en && (32'(addr) == i)) begin
                strobe[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/s_term_frame_writer.sv
// Frame writer: header/data(/checksum) words -> one-hot frame strobe into a column.
// Optional checksum word enabled by defining FRAME_WRITER_CHECKSUM_EN.
module s_term_frame_writer
    import s_term_frame_writer_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter logic [7:0]  SyncByte        = SYNC_BYTE_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       RST,
    s_term_frame_writer_if.slave       s_if,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err,
    output logic [7:0]                 frames_written
);

    frame_writer_state_t        state_q, state_d;
    logic [7:0]                 addr_q, addr_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic                       err_q, err_d;
    logic [7:0]                 fw_q, fw_d;
    logic                       ready;
    logic                       hdr_ok;
`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] hdr_q, hdr_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
`endif

    assign hdr_ok = (s_if.s_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == SyncByte) &&
                    (32'(s_if.s_data[HDR_ADDR_MSB:HDR_ADDR_LSB]) < MaxFramesPerCol);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frame_data_d = frame_data_q;
        err_d        = 1'b0;
        fw_d         = fw_q;
        ready        = 1'b0;
`ifdef FRAME_WRITER_CHECKSUM_EN
        hdr_d        = hdr_q;
        data_d       = data_q;
`endif
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (s_if.s_valid) begin
                    if (hdr_ok) begin
                        addr_d  = s_if.s_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                        state_d = WAIT_DATA;
`ifdef FRAME_WRITER_CHECKSUM_EN
                        hdr_d   = s_if.s_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                ready = 1'b1;
                if (s_if.s_valid) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
                    data_d  = s_if.s_data;
                    state_d = WAIT_CHK;
`else
                    // FrameData is loaded only on entry to SETUP
                    frame_data_d = s_if.s_data;
                    state_d      = SETUP;
`endif
                end
            end
            WAIT_CHK: begin
                ready = 1'b1;
`ifdef FRAME_WRITER_CHECKSUM_EN
                if (s_if.s_valid) begin
                    if (s_if.s_data == (hdr_q ^ data_q)) begin
                        frame_data_d = data_q;
                        state_d      = SETUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                fw_d    = fw_q + 8'd1;
                state_d = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            frame_data_q <= '0;
            err_q        <= 1'b0;
            fw_q         <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
            hdr_q        <= '0;
            data_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            frame_data_q <= frame_data_d;
            err_q        <= err_d;
            fw_q         <= fw_d;
`ifdef FRAME_WRITER_CHECKSUM_EN
            hdr_q        <= hdr_d;
            data_q       <= data_d;
`endif
        end
    end

    frame_strobe_decoder #(
        .NumFrames(MaxFramesPerCol)
    ) u_decoder (
        .en    (state_q == STROBE),
        .addr  (addr_q),
        .strobe(FrameStrobe)
    );

    assign s_if.s_ready   = ready;
    assign FrameData      = frame_data_q;
    assign busy           = (state_q != IDLE);
    assign err            = err_q;
    assign frames_written = fw_q;

endmodule
